note_envelope: RTL

//  ADSR amplitude envelope between synth `top` (24-bit signed out_sig) and i2s_ctrl (D_L_I/D_R_I).
//  Key press/release from keypad_decoder gates the note; each audio sample is scaled by an
//  ENV_W-bit envelope that steps once per sample strobe. Removes clicks, gives note articulation.

---
 rtl/note_envelope_pkg.sv | 16 +
 rtl/note_envelope_env_scaler.sv | 42 ++++
 rtl/note_envelope.sv | 106 ++++++++++
 3 files changed

// File: rtl/note_envelope_pkg.sv
// note_envelope_pkg: shared envelope widths, default ADSR constants and state codes.
// Used by note_envelope and by keypad/LED logic that decodes state_o.
package note_envelope_pkg;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_ENV_W  = 16;
    localparam logic [15:0] DEF_ATTACK_STEP  = 16'h4000;
    localparam logic [15:0] DEF_DECAY_STEP   = 16'h1000;
    localparam logic [15:0] DEF_SUSTAIN_LVL  = 16'h8000;
    localparam logic [15:0] DEF_RELEASE_STEP = 16'h0800;
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_e;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
endpackage

// File: rtl/note_envelope_env_scaler.sv
// note_envelope_env_scaler: 2-stage signed sample x unsigned envelope scaler.
// Ports: clk_i/rst_i (async, active high); valid_i + sample_i captured on strobe;
//        env_i is the envelope already updated by that strobe (used one cycle later);
//        sample_o (held between results) and one-cycle valid_o, two cycles after valid_i.
module note_envelope_env_scaler
    import note_envelope_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ENV_W  = DEF_ENV_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [ENV_W-1:0]  env_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              valid_o
);
    logic signed [DATA_W-1:0] s_q;
    logic                     v1_q;
    logic signed [DATA_W+ENV_W:0] prod;

    // Envelope is zero-extended so it acts as a non-negative gain below 1.0.
    assign prod = s_q * $signed({1'b0, env_i});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q      <= '0;
            v1_q     <= 1'b0;
            sample_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            v1_q    <= valid_i;
            valid_o <= v1_q;
            if (valid_i)
                s_q <= sample_i;
            // Arithmetic shift truncates toward -inf; |gain| < 1 so no saturation.
            if (v1_q)
                sample_o <= DATA_W'(prod >>> ENV_W);
        end
    end
endmodule

// File: rtl/note_envelope.sv
// note_envelope: ADSR amplitude envelope applied to a signed audio sample stream.
// Ports: clk_i, rst_i (async, active high); key_pressed_i note gate (level);
//        sample_valid_i strobe qualifying sample_i and advancing the envelope;
//        sample_o/valid_o scaled result (latency 2); env_o level; state_o FSM state;
//        note_active_o high whenever state is not IDLE.
module note_envelope
    import note_envelope_pkg::*;
#(
    parameter int               DATA_W       = DEF_DATA_W,
    parameter int               ENV_W        = DEF_ENV_W,
    parameter logic [ENV_W-1:0] ATTACK_STEP  = DEF_ATTACK_STEP,
    parameter logic [ENV_W-1:0] DECAY_STEP   = DEF_DECAY_STEP,
    parameter logic [ENV_W-1:0] SUSTAIN_LVL  = DEF_SUSTAIN_LVL,
    parameter logic [ENV_W-1:0] RELEASE_STEP = DEF_RELEASE_STEP
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              key_pressed_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              valid_o,
    output logic [ENV_W-1:0]  env_o,
    output logic [2:0]        state_o,
    output logic              note_active_o
);
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    logic             key_q, press_pend, rel_pend;
    logic             rise, fall, press_ev, rel_ev;
    logic [2:0]       state_q, st_ev, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [ENV_W:0]   up, dn;

    assign rise = key_pressed_i & ~key_q;
    assign fall = ~key_pressed_i & key_q;
    // A fresh edge replaces whatever is pending, so only the latest edge survives.
    assign press_ev = rise | (press_pend & ~fall);
    assign rel_ev   = fall | (rel_pend & ~rise);

    // Extra top bit exposes attack overflow and decay underflow.
    assign up = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    assign dn = {1'b0, env_q} - {1'b0, DECAY_STEP};

    always_comb begin
        st_ev = (press_ev && state_q != ST_ATTACK) ? ST_ATTACK :
                (rel_ev && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                            state_q == ST_SUSTAIN)) ? ST_RELEASE : state_q;
        state_d = st_ev;
        env_d   = env_q;
        case (st_ev)
            ST_ATTACK: begin
                state_d = (up >= {1'b0, ENV_MAX}) ? ST_DECAY : ST_ATTACK;
                env_d   = (up >= {1'b0, ENV_MAX}) ? ENV_MAX : up[ENV_W-1:0];
            end
            ST_DECAY: begin
                state_d = (dn[ENV_W] || dn[ENV_W-1:0] <= SUSTAIN_LVL) ? ST_SUSTAIN : ST_DECAY;
                env_d   = (dn[ENV_W] || dn[ENV_W-1:0] <= SUSTAIN_LVL) ? SUSTAIN_LVL : dn[ENV_W-1:0];
            end
            ST_SUSTAIN: env_d = env_q;
            ST_RELEASE: begin
                state_d = (env_q <= RELEASE_STEP) ? ST_IDLE : ST_RELEASE;
                env_d   = (env_q <= RELEASE_STEP) ? '0 : env_q - RELEASE_STEP;
            end
            default: begin
                state_d = ST_IDLE;
                env_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q      <= 1'b0;
            press_pend <= 1'b0;
            rel_pend   <= 1'b0;
            state_q    <= ST_IDLE;
            env_q      <= '0;
        end else begin
            key_q <= key_pressed_i;
            if (sample_valid_i) begin
                press_pend <= 1'b0;
                rel_pend   <= 1'b0;
                state_q    <= state_d;
                env_q      <= env_d;
            end else begin
                press_pend <= press_ev;
                rel_pend   <= rel_ev;
            end
        end
    end

    note_envelope_env_scaler #(.DATA_W(DATA_W), .ENV_W(ENV_W)) u_scaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (sample_valid_i),
        .sample_i (sample_i),
        .env_i    (env_q),
        .sample_o (sample_o),
        .valid_o  (valid_o)
    );

    assign env_o         = env_q;
    assign state_o       = state_q;
    assign note_active_o = state_q != ST_IDLE;
endmodule
